msrv32_wb_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback (the selected writeback-mux result) and one long-latency multi-cycle unit such as a divider. It tracks the single outstanding multi-cycle destination register and stalls younger instructions on RAW/WAW hazards. It buffers the unit's result until the write port is free, and bounds unit starvation with a counter. It sits between the writeback-mux stage and the integer register file.

---
 rtl/msrv32_wb_arb_pkg.sv | 18 +
 rtl/msrv32_wb_hold_buf.sv | 53 +++++
 rtl/msrv32_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_msrv32_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states, grant
// encoding and register-address width.
package msrv32_wb_arb_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      HOLD = 2'd2
   } wb_arb_state_e;

   typedef enum logic {
      GNT_PIPE = 1'b0,
      GNT_MC   = 1'b1
   } wb_arb_gnt_e;

endpackage

// File: rtl/msrv32_wb_hold_buf.sv
// Holds the outstanding multi-cycle destination and its buffered result, flags
// RAW/WAW hazards against it, and times how long the unit can be starved.
module msrv32_wb_hold_buf
   import msrv32_wb_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_accept,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  mc_accept,
   input  logic [DATA_W-1:0]     mc_data,
   input  logic                  busy,
   input  logic                  pipe_wr_en,
   input  logic [REG_ADDR_W-1:0] pipe_rd_addr,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  starve_step,
   input  logic                  starve_clear,
   output logic [REG_ADDR_W-1:0] pend_rd,
   output logic [DATA_W-1:0]     hold_data,
   output logic                  hazard,
   output logic                  starve_done
);

   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STARVE_LIMIT);

   // Down-counts the pipeline wins still allowed while a result waits.
   logic [CNT_W-1:0] starve_left;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_rd     <= '0;
         hold_data   <= '0;
         starve_left <= CNT_INIT;
      end else begin
         if (issue_accept) pend_rd <= issue_rd;
         if (mc_accept) hold_data <= mc_data;
         if (starve_clear) starve_left <= CNT_INIT;
         else if (starve_step && starve_left != '0) starve_left <= starve_left - 1'b1;
      end
   end

   assign starve_done = (starve_left == '0);

   assign hazard = busy && (pend_rd != '0) &&
                   ((pend_rd == rs1_addr) || (pend_rd == rs2_addr) ||
                    (pipe_wr_en && (pend_rd == pipe_rd_addr)));

endmodule

// File: rtl/msrv32_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and one outstanding multi-cycle unit result.
//
// state | meaning
// IDLE  | no multi-cycle op outstanding, pipeline owns the port
// PEND  | op issued, waiting for the unit result
// HOLD  | result buffered, waiting to win the write port
module msrv32_wb_arbiter
   import msrv32_wb_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = 32
) (
   input  logic                  ms_riscv32_mp_clk_in,
   input  logic                  ms_riscv32_mp_rst_in,
   input  logic                  pipe_wr_en_in,
   input  logic [REG_ADDR_W-1:0] pipe_rd_addr_in,
   input  logic [DATA_W-1:0]     pipe_wb_data_in,
   output logic                  pipe_stall_out,
   input  logic [REG_ADDR_W-1:0] rs1_addr_in,
   input  logic [REG_ADDR_W-1:0] rs2_addr_in,
   input  logic                  mc_issue_in,
   input  logic [REG_ADDR_W-1:0] mc_issue_rd_in,
   output logic                  mc_issue_ready_out,
   input  logic                  mc_valid_in,
   input  logic [DATA_W-1:0]     mc_data_in,
   output logic                  mc_ready_out,
   output logic                  rf_wr_en_out,
   output logic [REG_ADDR_W-1:0] rf_rd_addr_out,
   output logic [DATA_W-1:0]     rf_wr_data_out,
   output logic                  busy_out
);

   wb_arb_state_e state_q, state_d;
   wb_arb_gnt_e   gnt;

   logic                  issue_accept;
   logic                  mc_accept;
   logic                  unit_wins;
   logic                  pipe_go;
   logic                  hazard;
   logic                  starve_done;
   logic [REG_ADDR_W-1:0] pend_rd;
   logic [DATA_W-1:0]     hold_data;

   msrv32_wb_hold_buf #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .DATA_W       (DATA_W)
   ) u_hold_buf (
      .clk          (ms_riscv32_mp_clk_in),
      .rst          (ms_riscv32_mp_rst_in),
      .issue_accept (issue_accept),
      .issue_rd     (mc_issue_rd_in),
      .mc_accept    (mc_accept),
      .mc_data      (mc_data_in),
      .busy         (busy_out),
      .pipe_wr_en   (pipe_wr_en_in),
      .pipe_rd_addr (pipe_rd_addr_in),
      .rs1_addr     (rs1_addr_in),
      .rs2_addr     (rs2_addr_in),
      .starve_step  ((state_q == HOLD) && !unit_wins),
      .starve_clear (unit_wins),
      .pend_rd      (pend_rd),
      .hold_data    (hold_data),
      .hazard       (hazard),
      .starve_done  (starve_done)
   );

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) state_q <= IDLE;
      else                      state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      issue_accept = 1'b0;
      mc_accept    = 1'b0;
      unit_wins    = 1'b0;
      case (state_q)
         IDLE: begin
            if (mc_issue_in) begin
               state_d      = PEND;
               issue_accept = 1'b1;
            end
         end
         PEND: begin
            if (mc_valid_in) begin
               state_d   = HOLD;
               mc_accept = 1'b1;
            end
         end
         HOLD: begin
            unit_wins = !pipe_wr_en_in || starve_done;
            if (unit_wins) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      gnt            = unit_wins ? GNT_MC : GNT_PIPE;
      pipe_stall_out = hazard || (unit_wins && pipe_wr_en_in);
      pipe_go        = pipe_wr_en_in && !pipe_stall_out;
   end

   assign mc_issue_ready_out = (state_q == IDLE);
   assign mc_ready_out       = (state_q == PEND);
   assign busy_out           = (state_q != IDLE);

   // x0 writes still retire their transaction but never reach the register file.
   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         rf_wr_en_out   <= 1'b0;
         rf_rd_addr_out <= '0;
         rf_wr_data_out <= '0;
      end else if (gnt == GNT_MC) begin
         rf_wr_en_out   <= (pend_rd != '0);
         rf_rd_addr_out <= pend_rd;
         rf_wr_data_out <= hold_data;
      end else begin
         rf_wr_en_out   <= pipe_go && (pipe_rd_addr_in != '0);
         rf_rd_addr_out <= pipe_rd_addr_in;
         rf_wr_data_out <= pipe_wb_data_in;
      end
   end

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Directed bench for msrv32_wb_arbiter: expected register-file writes are queued
// with their due cycle and matched by a monitor; control outputs checked inline.
module tb_msrv32_wb_arbiter;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pipe_wr_en = 1'b0;
   logic [4:0]        pipe_rd = '0;
   logic [DATA_W-1:0] pipe_data = '0;
   logic              pipe_stall;
   logic [4:0]        rs1 = '0;
   logic [4:0]        rs2 = '0;
   logic              mc_issue = 1'b0;
   logic [4:0]        mc_issue_rd = '0;
   logic              mc_issue_ready;
   logic              mc_valid = 1'b0;
   logic [DATA_W-1:0] mc_data = '0;
   logic              mc_ready;
   logic              rf_wr_en;
   logic [4:0]        rf_rd_addr;
   logic [DATA_W-1:0] rf_wr_data;
   logic              busy;

   msrv32_wb_arbiter #(.STARVE_LIMIT(4), .DATA_W(DATA_W)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .pipe_wr_en_in        (pipe_wr_en),
      .pipe_rd_addr_in      (pipe_rd),
      .pipe_wb_data_in      (pipe_data),
      .pipe_stall_out       (pipe_stall),
      .rs1_addr_in          (rs1),
      .rs2_addr_in          (rs2),
      .mc_issue_in          (mc_issue),
      .mc_issue_rd_in       (mc_issue_rd),
      .mc_issue_ready_out   (mc_issue_ready),
      .mc_valid_in          (mc_valid),
      .mc_data_in           (mc_data),
      .mc_ready_out         (mc_ready),
      .rf_wr_en_out         (rf_wr_en),
      .rf_rd_addr_out       (rf_rd_addr),
      .rf_wr_data_out       (rf_wr_data),
      .busy_out             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]        addr;
      logic [DATA_W-1:0] data;
      int                cyc;
   } wr_t;

   wr_t exp_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every presented write must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && rf_wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h, none expected", cyc, rf_rd_addr, rf_wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (rf_rd_addr !== e.addr || rf_wr_data !== e.data || cyc != e.cyc) begin
               failures++;
               $display("FAIL rf_write got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        rf_rd_addr, rf_wr_data, cyc, e.addr, e.data, e.cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_wr(input logic [4:0] a, input logic [DATA_W-1:0] d, input int dly);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = cyc + dly;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (cyc=%0d)", name, got, want, cyc);
      end
   endtask

   task automatic chk_stall(input string name, input logic want);
      #1;
      chk(name, DATA_W'(pipe_stall), DATA_W'(want));
   endtask

   task automatic pipe(input logic en, input logic [4:0] rd, input logic [DATA_W-1:0] d);
      pipe_wr_en = en;
      pipe_rd    = rd;
      pipe_data  = d;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr_en"}, DATA_W'(rf_wr_en), '0);
      chk({tag, "_addr"}, DATA_W'(rf_rd_addr), '0);
      chk({tag, "_data"}, rf_wr_data, '0);
      chk({tag, "_issue_ready"}, DATA_W'(mc_issue_ready), 1);
      chk({tag, "_mc_ready"}, DATA_W'(mc_ready), '0);
      chk({tag, "_busy"}, DATA_W'(busy), '0);
      chk({tag, "_stall"}, DATA_W'(pipe_stall), '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Pipeline-only writes, x0 suppressed
      step();
      pipe(1, 5'd5, 32'h1234); exp_wr(5'd5, 32'h1234, 1); chk_stall("p_x5_stall", 0);
      step();
      pipe(1, 5'd0, 32'hFFFF); chk_stall("p_x0_stall", 0);
      step();
      pipe(0, 5'd0, '0);
      step();
      chk("p_x0_no_write", DATA_W'(rf_wr_en), '0);

      // RAW on x7, unit wins immediately when pipeline is idle
      mc_issue = 1; mc_issue_rd = 5'd7; chk_stall("raw_issue_stall", 0);
      step();
      mc_issue = 0; rs1 = 5'd7; chk_stall("raw_pend_stall", 1);
      chk("raw_issue_ready", DATA_W'(mc_issue_ready), '0);
      chk("raw_mc_ready", DATA_W'(mc_ready), 1);
      chk("raw_busy", DATA_W'(busy), 1);
      step();
      chk_stall("raw_pend_stall2", 1);
      mc_valid = 1; mc_data = 32'hDEAD; exp_wr(5'd7, 32'hDEAD, 2);
      step();
      mc_valid = 0; chk_stall("raw_hold_stall", 1);
      step();
      chk_stall("raw_release", 0);
      rs1 = 0;

      // Starvation bound: four pipeline wins, then the unit
      step();
      mc_issue = 1; mc_issue_rd = 5'd7;
      step();
      mc_issue = 0; mc_valid = 1; mc_data = 32'hBEEF;
      pipe(1, 5'd3, 32'h30); exp_wr(5'd3, 32'h30, 1); chk_stall("st_pend", 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         mc_valid = 0;
         pipe(1, 5'd3, 32'h30 + i); exp_wr(5'd3, 32'h30 + i, 1); chk_stall("st_pipe_win", 0);
      end
      step();
      pipe(1, 5'd3, 32'h35); exp_wr(5'd7, 32'hBEEF, 1); chk_stall("st_unit_forced", 1);
      step();
      exp_wr(5'd3, 32'h35, 1); chk_stall("st_resume", 0);
      step();
      pipe(0, 5'd0, '0);

      // WAW on x9: pipeline value must land last
      step();
      mc_issue = 1; mc_issue_rd = 5'd9;
      step();
      mc_issue = 0; pipe(1, 5'd9, 32'h99); chk_stall("waw_pend", 1);
      step();
      mc_valid = 1; mc_data = 32'h1111; chk_stall("waw_pend2", 1);
      for (int i = 0; i < 4; i++) begin
         step();
         mc_valid = 0; chk_stall("waw_hold", 1);
      end
      step();
      exp_wr(5'd9, 32'h1111, 1); chk_stall("waw_unit", 1);
      step();
      exp_wr(5'd9, 32'h99, 1); chk_stall("waw_resume", 0);
      step();
      pipe(0, 5'd0, '0);

      // Ignored valid in IDLE and second issue in PEND
      step();
      mc_valid = 1; mc_data = 32'h5555;
      #1 chk("ign_mc_ready_idle", DATA_W'(mc_ready), '0);
      step();
      mc_valid = 0; chk("ign_busy", DATA_W'(busy), '0);
      mc_issue = 1; mc_issue_rd = 5'd12;
      step();
      mc_issue_rd = 5'd13;
      #1 chk("ign_issue_ready_pend", DATA_W'(mc_issue_ready), '0);
      step();
      mc_issue = 0; mc_valid = 1; mc_data = 32'hC0DE; exp_wr(5'd12, 32'hC0DE, 2);
      step();
      mc_valid = 0;
      step();
      chk("ign_idle_after", DATA_W'(busy), '0);

      // Reset while a result is buffered
      step();
      mc_issue = 1; mc_issue_rd = 5'd20;
      step();
      mc_issue = 0; mc_valid = 1; mc_data = 32'hBAD;
      pipe(1, 5'd4, 32'h44); exp_wr(5'd4, 32'h44, 1);
      step();
      mc_valid = 0; pipe(1, 5'd3, 32'h33);
      step();
      pipe(0, 5'd0, '0);
      chk("rst_pre_wr_en", DATA_W'(rf_wr_en), 1);
      chk("rst_pre_busy", DATA_W'(busy), 1);
      rst = 1;
      #1 chk_reset_outputs("rst_hold");
      step();
      step();
      rst = 0;
      for (int i = 0; i < 6; i++) step();
      chk("rst_after_issue_ready", DATA_W'(mc_issue_ready), 1);
      chk("rst_after_busy", DATA_W'(busy), '0);

      step();
      chk("exp_queue_empty", DATA_W'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
